// File: rtl/mult_share_arb_if.sv
// rtl/mult_share_arb_if.sv - requester/consumer bundle for the shared multiplier arbiter
interface mult_share_arb_if;
  logic [3:0]  req_valid;
  logic [11:0] req_a;
  logic [11:0] req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [5:0]  resp_y;
  logic [1:0]  resp_id;
  logic        busy;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_y, resp_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_y, resp_id, busy
  );
endinterface

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - four-requester round-robin arbiter sharing one signed 3x3 multiplier
// Defining MULT_SHARE_ARB_COUNT_EN adds the op_count completion counter output.
module exact_mult (
  input  logic signed [2:0] i_a,
  input  logic signed [2:0] i_b,
  output logic signed [5:0] o_y
);
  logic signed [5:0] w_a_ext;
  logic signed [5:0] w_b_ext;

  assign w_a_ext = {{3{i_a[2]}}, i_a};
  assign w_b_ext = {{3{i_b[2]}}, i_b};
  // Six bits cover the full -12..16 range, so -4*-4 needs no saturation.
  assign o_y = w_a_ext * w_b_ext;
endmodule

module mult_share_arb (
  input  logic              clk,
  input  logic              rst_n,
  mult_share_arb_if.slave   bus
`ifdef MULT_SHARE_ARB_COUNT_EN
  ,
  output logic [7:0]        op_count
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_rr_ptr;
  logic [1:0]        r_id;
  logic [1:0]        r_resp_id;
  logic signed [2:0] r_a;
  logic signed [2:0] r_b;
  logic signed [5:0] r_y;
  logic signed [5:0] w_prod;
  logic [1:0]        w_grant_idx;
  logic [1:0]        w_cand;
  logic              w_grant_any;
  logic [2:0]        w_sel_a;
  logic [2:0]        w_sel_b;
  logic [3:0]        w_req_ready;

  assign w_grant_any = |bus.req_valid;

  // Walk downward in offset so the nearest set bit above rr_ptr wins last.
  always_comb begin
    w_grant_idx = r_rr_ptr;
    w_cand      = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_rr_ptr + 2'(k);
      if (bus.req_valid[w_cand]) begin
        w_grant_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_a = bus.req_a[2:0];
    w_sel_b = bus.req_b[2:0];
    case (w_grant_idx)
      2'd0: begin w_sel_a = bus.req_a[2:0];  w_sel_b = bus.req_b[2:0];  end
      2'd1: begin w_sel_a = bus.req_a[5:3];  w_sel_b = bus.req_b[5:3];  end
      2'd2: begin w_sel_a = bus.req_a[8:6];  w_sel_b = bus.req_b[8:6];  end
      default: begin w_sel_a = bus.req_a[11:9]; w_sel_b = bus.req_b[11:9]; end
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 4'b0000;
    case (r_state)
      IDLE: begin
        if (rst_n && w_grant_any) begin
          w_req_ready  = 4'b0001 << w_grant_idx;
          w_next_state = EXEC;
        end
      end
      EXEC: w_next_state = DONE;
      DONE: begin
        if (bus.resp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  exact_mult u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_y (w_prod)
  );

`ifdef MULT_SHARE_ARB_COUNT_EN
  logic [7:0] r_op_count;
  assign op_count = r_op_count;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr_ptr  <= 2'd0;
      r_id      <= 2'd0;
      r_resp_id <= 2'd0;
      r_a       <= 3'sd0;
      r_b       <= 3'sd0;
      r_y       <= 6'sd0;
`ifdef MULT_SHARE_ARB_COUNT_EN
      r_op_count <= 8'd0;
`endif
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_id <= w_grant_idx;
          end
        end
        EXEC: begin
          r_y       <= w_prod;
          r_resp_id <= r_id;
        end
        DONE: begin
          if (bus.resp_ready) begin
            r_rr_ptr <= r_resp_id + 2'd1;
`ifdef MULT_SHARE_ARB_COUNT_EN
            r_op_count <= r_op_count + 8'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = (r_state == DONE);
  assign bus.resp_y     = r_y;
  assign bus.resp_id    = r_resp_id;
  assign bus.busy       = (r_state != IDLE);
endmodule
